serial_frame_accumulator: RTL and testbench

//  Downstream stage of the 4:1 round-robin output mux in the block-multiply datapath.
//  - Consumes the serialized 16-bit partial-product stream, one word per clock.
//  - Regroups every LANES consecutive words into one frame, in lane order 0..LANES-1.
//  - Presents the frame as a parallel word vector plus its signed sum.
//  - Output side uses a valid/ready handshake to the block-result writer.

---
 rtl/serial_frame_accumulator.sv | 151 +++++++++++++++
 tb/tb_serial_frame_accumulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_accumulator.sv
// ---------------------------------------------------------------------------
// serial_frame_accumulator
//
// Purpose:
//   Takes the serialized signed partial-product stream coming out of the 4:1
//   round-robin output mux, one word per clock. It groups every LANES
//   consecutive words into one frame in lane order 0..LANES-1. Each frame is
//   presented as a parallel word vector together with its signed sum, behind
//   a valid/ready handshake.
//   A frame that completes while the output register is still occupied is
//   dropped and counted. The counter saturates at 255.
//
// Optional feature (compile-time macro FRAME_SYNC_EN):
//   Adds the in_sync input. A valid word marked in_sync is forced to lane 0.
//   Any partial frame in progress at that moment is discarded and counted as
//   a drop.
//
// Ports:
//   clock      in   1             rising-edge clock
//   reset      in   1             asynchronous active-low reset
//   in_valid   in   1             in_data carries a word this cycle (no backpressure)
//   in_data    in   DATA_W        serialized signed word
//   in_sync    in   1             word starts a new frame (FRAME_SYNC_EN only)
//   out_valid  out  1             a frame is held on out_words/out_sum
//   out_ready  in   1             consumer takes the frame when out_valid && out_ready
//   out_words  out  DATA_W*LANES  lane k in bits [k*DATA_W +: DATA_W]
//   out_sum    out  ACC_W         signed sum of the frame's words
//   drop_cnt   out  8             dropped-frame count, saturating at 255
// ---------------------------------------------------------------------------
module serial_frame_accumulator #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 18
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
`ifdef FRAME_SYNC_EN
    input  logic                     in_sync,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W*LANES-1:0]  out_words,
    output logic [ACC_W-1:0]         out_sum,
    output logic [7:0]               drop_cnt
);

    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]        lane;
    logic [ACC_W-1:0]         acc;
    logic [DATA_W-1:0]        staging [LANES];

    logic [LANE_W-1:0]        lane_eff;       // lane this word lands in, after any resync
    logic [ACC_W-1:0]         acc_base;       // accumulator value this word is added to
    logic [ACC_W-1:0]         word_ext;
    logic [ACC_W-1:0]         sum_next;
    logic                     drop_partial;
    logic                     frame_done;
    logic                     out_free;
    logic                     load_out;
    logic                     bump_drop;
    logic [DATA_W*LANES-1:0]  frame_words;

    assign word_ext = ACC_W'($signed(in_data));

    // NOTE: every signal written in a combinational block is given a default
    // first. Any path that leaves a signal unassigned would infer a latch.
    always_comb begin
        lane_eff     = lane;
        acc_base     = acc;
        drop_partial = 1'b0;
`ifdef FRAME_SYNC_EN
        // A sync word starts a new frame. Words already collected are abandoned.
        if (in_valid && in_sync) begin
            lane_eff     = '0;
            acc_base     = '0;
            drop_partial = (lane != '0);
        end
`endif
        sum_next   = acc_base + word_ext;
        frame_done = in_valid && (lane_eff == LAST_LANE);
        // The output register can take a new frame in the same cycle that it
        // hands the current frame off. This lets back-to-back frames stream
        // through without a drop.
        out_free   = !out_valid || out_ready;
        load_out   = frame_done && out_free;
        bump_drop  = (frame_done && !out_free) || drop_partial;
    end

    // The final word goes to the output register directly from in_data.
    // It is never read back out of staging.
    always_comb begin
        frame_words = '0;
        for (int k = 0; k < LANES; k++) begin
            frame_words[k*DATA_W +: DATA_W] = (k == LANES - 1) ? in_data : staging[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the clock edge, whatever the
    // order of the blocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane <= '0;
            acc  <= '0;
        end else if (in_valid) begin
            if (frame_done) begin
                lane <= '0;
                acc  <= '0;
            end else begin
                lane <= lane_eff + LANE_W'(1);
                acc  <= sum_next;
            end
        end
    end

    // NOTE: the staging slots are plain data storage and are not reset.
    // After reset, every slot is rewritten before any frame can complete, so
    // the contents left over from before reset are never observed.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            staging[lane_eff] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_words <= '0;
            out_sum   <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_words <= frame_words;
            out_sum   <= sum_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (bump_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_serial_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_accumulator
//
// Purpose:
//   Bench for serial_frame_accumulator with its default parameters.
//   A queue-based reference model tracks the expected outputs: the words of
//   the frame being collected, the frame held at the output, and the drop
//   count. All four outputs are compared against this model on every falling
//   clock edge. Directed scenarios add literal expectations, followed by a
//   randomized stream. Define FRAME_SYNC_EN to also cover the in_sync input.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_serial_frame_accumulator;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int ACC_W  = 18;
    localparam int OUT_W  = DATA_W * LANES;

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_ready = 1'b0;
`ifdef FRAME_SYNC_EN
    logic              in_sync   = 1'b0;
`endif
    logic              out_valid;
    logic [OUT_W-1:0]  out_words;
    logic [ACC_W-1:0]  out_sum;
    logic [7:0]        drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    serial_frame_accumulator #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef FRAME_SYNC_EN
        .in_sync   (in_sync),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_words (out_words),
        .out_sum   (out_sum),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               q[$];            // signed words of the frame being collected
    logic             m_valid = 1'b0;
    logic [OUT_W-1:0] m_words = '0;
    int               m_sum   = 0;
    int               m_drop  = 0;
    logic             m_accepted;
    logic             m_loaded;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_valid = 1'b0;
            m_words = '0;
            m_sum   = 0;
            m_drop  = 0;
        end else begin
            m_accepted = m_valid && out_ready;
            m_loaded   = 1'b0;
            if (in_valid) begin
`ifdef FRAME_SYNC_EN
                if (in_sync) begin
                    if (q.size() != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    q.delete();
                end
`endif
                q.push_back(int'($signed(in_data)));
                if (q.size() == LANES) begin
                    if (!m_valid || out_ready) begin
                        m_loaded = 1'b1;
                        m_valid  = 1'b1;
                        m_sum    = 0;
                        for (int i = 0; i < LANES; i++) begin
                            m_words[i*DATA_W +: DATA_W] = DATA_W'(q[i]);
                            m_sum += q[i];
                        end
                    end else begin
                        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    end
                    q.delete();
                end
            end
            if (m_accepted && !m_loaded) m_valid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [ACC_W-1:0] exp_sum;
    logic [7:0]       exp_drop;

    always @(negedge clock) begin
        exp_sum  = ACC_W'(m_sum);
        exp_drop = 8'(m_drop);
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("drop_cnt",  128'(drop_cnt),  128'(exp_drop));
        check("out_words", 128'(out_words), 128'(m_words));
        check("out_sum",   128'(out_sum),   128'(exp_sum));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

`ifdef FRAME_SYNC_EN
    task automatic send_sync(input logic [DATA_W-1:0] d);
        in_sync = 1'b1;
        send(d);
        in_sync = 1'b0;
    endtask
`endif

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset drop_cnt",  128'(drop_cnt),  128'(0));

        // 1: basic frame, then back-to-back frames with out_ready held high
        out_ready = 1'b1;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        check("t1 out_valid", 128'(out_valid), 128'(1));
        check("t1 out_words", 128'(out_words), 128'(64'h0004_0003_0002_0001));
        check("t1 out_sum",   128'(out_sum),   128'(18'd10));
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < LANES; k++) send(16'(f * 16 + k));
        end
        check("t1 b2b drop_cnt", 128'(drop_cnt), 128'(0));

        // 2: sign extension at the extremes
        send(16'h8000); send(16'h8000); send(16'h7FFF); send(16'h7FFF);
        check("t2 neg sum", 128'(out_sum), 128'(18'h3FFFE));
        send(16'h7FFF); send(16'h7FFF); send(16'h7FFF); send(16'h7FFF);
        check("t2 pos sum",   128'(out_sum),   128'(18'h1FFFC));
        check("t2 pos words", 128'(out_words), 128'(64'h7FFF_7FFF_7FFF_7FFF));

        // 3: backpressure - hold frame 1, drop frames 2 and 3
        tick();
        check("t3 drained", 128'(out_valid), 128'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'(16'h100 + i));
        check("t3 held words", 128'(out_words), 128'(64'h0103_0102_0101_0100));
        check("t3 held sum",   128'(out_sum),   128'(18'd1030));
        check("t3 drop_cnt",   128'(drop_cnt),  128'(2));
        out_ready = 1'b1;
        tick();
        check("t3 after accept", 128'(out_valid), 128'(0));

        // 4: gaps inside a frame
        send(16'd5); send(16'd6);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("t4 gap out_valid", 128'(out_valid), 128'(0));
        end
        send(16'd7); send(16'd8);
        check("t4 sum",   128'(out_sum),   128'(18'd26));
        check("t4 words", 128'(out_words), 128'(64'h0008_0007_0006_0005));

`ifdef FRAME_SYNC_EN
        // 5: resync discards a partial frame; sync at lane 0 is a no-op
        do_reset();
        out_ready = 1'b1;
        send(16'd9); send(16'd9);
        send_sync(16'd1); send(16'd2); send(16'd3); send(16'd4);
        check("t5 drop_cnt", 128'(drop_cnt),  128'(1));
        check("t5 words",    128'(out_words), 128'(64'h0004_0003_0002_0001));
        check("t5 sum",      128'(out_sum),   128'(18'd10));
        in_sync = 1'b1;
        tick();
        in_sync = 1'b0;
        send_sync(16'd5); send(16'd6); send(16'd7); send(16'd8);
        check("t5 realign drop_cnt", 128'(drop_cnt), 128'(1));
        check("t5 realign sum",      128'(out_sum),  128'(18'd26));
`endif

        // 6: asynchronous reset with a frame held and a partial frame pending
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(i + 1));
        send(16'hAAAA); send(16'hBBBB);
        check("t6 pre drop_cnt", 128'(drop_cnt), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("t6 async out_valid", 128'(out_valid), 128'(0));
        check("t6 async out_words", 128'(out_words), 128'(0));
        check("t6 async out_sum",   128'(out_sum),   128'(0));
        check("t6 async drop_cnt",  128'(drop_cnt),  128'(0));
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        send(16'h11); send(16'h22); send(16'h33); send(16'h44);
        check("t6 clean words", 128'(out_words), 128'(64'h0044_0033_0022_0011));
        check("t6 clean sum",   128'(out_sum),   128'(18'd170));

        // 7: drop counter saturation
        out_ready = 1'b0;
        for (int f = 0; f < 262; f++) begin
            for (int k = 0; k < LANES; k++) send(16'($urandom));
        end
        check("t7 saturated", 128'(drop_cnt), 128'(255));
        out_ready = 1'b1;
        tick();

        // 8: randomized stream with a mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
`ifdef FRAME_SYNC_EN
            in_sync   = ($urandom_range(0, 19) == 0);
`endif
            tick();
        end
        in_valid = 1'b0;
`ifdef FRAME_SYNC_EN
        in_sync  = 1'b0;
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
